// File: rtl/tangram_pkg.sv
// rtl/tangram_pkg.sv - shared move/button indices and repeat-state type for the tangram command path
package tangram_pkg;

  localparam int NUM_DIRS = 4;
  localparam int NUM_BTNS = 5;

  // Move bit positions; the segment-display stage decodes o_Move with these.
  localparam int MOVE_UP    = 0;
  localparam int MOVE_DOWN  = 1;
  localparam int MOVE_LEFT  = 2;
  localparam int MOVE_RIGHT = 3;
  localparam logic [NUM_DIRS-1:0] MOVE_NONE = 4'b0000;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_e;

  // Lowest index wins, which gives up > down > left > right.
  function automatic logic [NUM_DIRS-1:0] prio_pick(input logic [NUM_DIRS-1:0] req);
    logic [NUM_DIRS-1:0] grant;
    grant = MOVE_NONE;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = MOVE_NONE;
        grant[i] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchroniser, debounce counter and registered press strobe
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, press_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // level_q trails stable_q by one cycle, so their difference is the rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      level_q  <= stable_q;
      press_q  <= stable_q & ~level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/button_cmd_decoder.sv
// rtl/button_cmd_decoder.sv - debounced buttons to one-hot move / rotate strobes with auto-repeat
module button_cmd_decoder
  import tangram_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Btn_Up,
  input  logic       i_Btn_Down,
  input  logic       i_Btn_Left,
  input  logic       i_Btn_Right,
  input  logic       i_Btn_Center,
  output logic [3:0] o_Move,
  output logic       o_Rotate,
  output logic [4:0] o_Btn_Level
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

  logic [NUM_BTNS-1:0] btn_raw, btn_level, btn_press;
  logic [NUM_DIRS-1:0] dir_evt;
  logic [NUM_DIRS-1:0] move_q, move_d;
  logic                rotate_q, rotate_d;

  always_comb begin
    btn_raw             = '0;
    btn_raw[BTN_UP]     = i_Btn_Up;
    btn_raw[BTN_DOWN]   = i_Btn_Down;
    btn_raw[BTN_LEFT]   = i_Btn_Left;
    btn_raw[BTN_RIGHT]  = i_Btn_Right;
    btn_raw[BTN_CENTER] = i_Btn_Center;
  end

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i  (i_Clk),
      .rst_i  (i_Rst),
      .btn_i  (btn_raw[b]),
      .level_o(btn_level[b]),
      .press_o(btn_press[b])
    );
  end

  // Direction button index d is also its move bit, so each timer feeds dir_evt[d] directly.
  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_rpt
    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] cnt_q, cnt_d;
    logic             fire;
    logic [RPT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == {RPT_W{1'b1}}) ? cnt_q : cnt_q + RPT_ONE;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire    = 1'b0;
      case (state_q)
        RPT_IDLE: begin
          if (btn_press[d]) begin
            fire = 1'b1;
            if (REPEAT_DELAY != 0) begin
              state_d = RPT_DELAY;
              cnt_d   = RPT_ONE;
            end
          end
        end
        RPT_DELAY: begin
          if (!btn_level[d]) begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DELAY_LAST) begin
            fire    = 1'b1;
            state_d = RPT_PERIOD;
            cnt_d   = RPT_ONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RPT_PERIOD: begin
          if (!btn_level[d]) begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == PERIOD_LAST) begin
            fire  = 1'b1;
            cnt_d = RPT_ONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        state_q <= RPT_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign dir_evt[d] = fire;
  end

  always_comb begin
    move_d   = prio_pick(dir_evt);
    rotate_d = btn_press[BTN_CENTER];
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      move_q   <= MOVE_NONE;
      rotate_q <= 1'b0;
    end else begin
      move_q   <= move_d;
      rotate_q <= rotate_d;
    end
  end

  assign o_Move      = move_q;
  assign o_Rotate    = rotate_q;
  assign o_Btn_Level = btn_level;

endmodule

// File: tb/tb_button_cmd_decoder.sv
// tb/tb_button_cmd_decoder.sv - scoreboard bench for button_cmd_decoder with short timing parameters
module tb_button_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
  logic [3:0] move;
  logic       rotate;
  logic [4:0] level;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    int         cyc;
    logic [3:0] mv;
    logic       rot;
  } exp_t;

  exp_t exp_q[$];

  button_cmd_decoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Btn_Up    (up),
    .i_Btn_Down  (down),
    .i_Btn_Left  (left),
    .i_Btn_Right (right),
    .i_Btn_Center(center),
    .o_Move      (move),
    .o_Rotate    (rotate),
    .o_Btn_Level (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
  endtask

  task automatic push(input int c, input logic [3:0] mv, input logic rot);
    exp_t e;
    e.cyc = c;
    e.mv  = mv;
    e.rot = rot;
    exp_q.push_back(e);
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every nonzero strobe must match the oldest expected event exactly.
  always @(negedge clk) begin
    if (move != 4'b0000 || rotate) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_strobe", {27'd0, rotate, move}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(cyc == e.cyc, "strobe_cycle", cyc, e.cyc);
        chk({rotate, move} == {e.rot, e.mv}, "strobe_value", {27'd0, rotate, move}, {27'd0, e.rot, e.mv});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b;

    at_cycle(2);
    chk(move == 4'b0000, "reset_move", move, 0);
    chk(rotate == 1'b0, "reset_rotate", rotate, 0);
    chk(level == 5'b00000, "reset_level", level, 0);
    at_cycle(3);
    rst = 1'b0;

    // 1: clean up press held 10 cycles
    b = 10;
    push(b + 7, 4'b0001, 1'b0);
    at_cycle(b - 1);
    up = 1'b1;
    at_cycle(b + 5);
    chk(level == 5'b00000, "t1_level_c5", level, 0);
    at_cycle(b + 6);
    chk(level == 5'b00001, "t1_level_c6", level, 1);
    at_cycle(b + 9);
    up = 1'b0;
    at_cycle(b + 15);
    chk(level == 5'b00001, "t1_level_rel5", level, 1);
    at_cycle(b + 16);
    chk(level == 5'b00000, "t1_level_rel6", level, 0);

    // 2: bouncing right button, settles high from cycle 12
    b = 60;
    push(b + 19, 4'b1000, 1'b0);
    for (int k = 0; k <= 12; k++) begin
      at_cycle(b + k - 1);
      right = ((k % 4) < 2);
    end
    at_cycle(b + 21);
    right = 1'b0;

    // 3: up and left together, up wins
    b = 120;
    push(b + 7, 4'b0001, 1'b0);
    at_cycle(b - 1);
    up   = 1'b1;
    left = 1'b1;
    at_cycle(b + 9);
    up   = 1'b0;
    left = 1'b0;

    // 4: centre and down together; centre held long, no repeat
    b = 170;
    push(b + 7, 4'b0010, 1'b1);
    at_cycle(b - 1);
    center = 1'b1;
    down   = 1'b1;
    at_cycle(b + 9);
    down = 1'b0;
    at_cycle(b + 99);
    center = 1'b0;

    // 5: left held 50 cycles, auto-repeat
    b = 310;
    push(b + 7,  4'b0100, 1'b0);
    push(b + 27, 4'b0100, 1'b0);
    push(b + 35, 4'b0100, 1'b0);
    push(b + 43, 4'b0100, 1'b0);
    push(b + 51, 4'b0100, 1'b0);
    at_cycle(b - 1);
    left = 1'b1;
    at_cycle(b + 49);
    left = 1'b0;

    // 6: up held across a reset pulse; deassertion edge is b+8
    b = 400;
    push(b + 15, 4'b0001, 1'b0);
    at_cycle(b - 1);
    up = 1'b1;
    at_cycle(b + 4);
    rst = 1'b1;
    #1;
    chk(move == 4'b0000, "t6_rst_move", move, 0);
    chk(rotate == 1'b0, "t6_rst_rotate", rotate, 0);
    chk(level == 5'b00000, "t6_rst_level", level, 0);
    at_cycle(b + 6);
    chk(level == 5'b00000, "t6_rst_level_held", level, 0);
    at_cycle(b + 7);
    rst = 1'b0;
    at_cycle(b + 14);
    chk(level == 5'b00001, "t6_level_after_rst", level, 1);
    at_cycle(b + 19);
    up = 1'b0;

    at_cycle(b + 60);
    chk(exp_q.size() == 0, "missing_strobes", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
